hamming_secded_dec_p: RTL and testbench
=======================================

# hamming_secded_dec_p

Parametrised, pipelined SECDED (extended Hamming) decoder with valid/ready handshakes on both sides and saturating error-event counters. It replaces the fixed 8-bit/4-data-bit decoder in the receive path, sitting between the channel/deserialiser front end and the data consumer. It corrects any single-bit error, detects any double-bit error and reports the syndrome position for logging.

## Interface

- DATA_W, 4, number of data bits per codeword
- PAR_W, 3, number of Hamming parity bits; legal only if 2^PAR_W >= DATA_W+PAR_W+1; elaboration error otherwise
- CNT_W, 8, width of each error counter
- N (localparam) = DATA_W+PAR_W+1, codeword width
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  codeword valid
- in_ready  out  1  decoder can accept a codeword
- data_in  in  N  codeword: data_in[i] = Hamming position i+1 for i < N-1; data_in[N-1] = overall even parity
- out_valid  out  1  decoded result valid
- out_ready  in  1  consumer accepts the result
- data_out  out  DATA_W  data; data_out[0] = lowest non-power-of-two position
- err_correctable  out  1  single error corrected (qualified by out_valid)
- err_uncorrectable  out  1  double or invalid error detected (qualified by out_valid)
- err_pos  out  PAR_W  syndrome value of the result; 0 with err_correctable = overall parity bit in error
- clr_cnt  in  1  synchronous clear of both counters
- corr_cnt  out  CNT_W  count of correctable results delivered
- uncorr_cnt  out  CNT_W  count of uncorrectable results delivered

## Operation

- Parity bit j sits at position 2^j. Data bits occupy the remaining positions 3, 5, 6, 7, 9, … in ascending order.
- Syndrome S: bit j = XOR of all positions p in 1..N-1 whose index has bit j set. P = XOR of all N bits.
- Classification:
  - S=0, P=0: clean. Data is passed through; no flags.
  - P=1, S<=N-1: single error. Position S is inverted before data extraction; S=0 means the overall parity bit itself, so data is unchanged. Sets err_correctable.
  - P=1, S>N-1: shortened-code invalid syndrome. Sets err_uncorrectable.
  - P=0, S!=0: double error. Sets err_uncorrectable.
- On an uncorrectable result, data_out carries the raw, uncorrected data bits.
- err_correctable and err_uncorrectable are mutually exclusive.
- Stage 1 registers the codeword, S and P. Stage 2 registers the corrected data, flags and err_pos.
- Global pipeline enable: en = !out_valid || out_ready. Both stages advance only when en=1. in_ready = en.
- A codeword is accepted when in_valid && in_ready. A result is delivered when out_valid && out_ready.
- Counters increment on delivery of a flagged result and saturate at 2^CNT_W-1.
- clr_cnt in the same cycle as an increment: clear wins, and the counter reads 0 next cycle.

## Timing

- Latency: 2 cycles from acceptance to out_valid when unstalled. Throughput: 1 codeword per cycle.
- While out_valid=1 and out_ready=0:
  - data_out, the flags, err_pos and out_valid hold stable.
  - in_ready=0.
  - The stage-1 contents are held.
- in_ready is combinational from out_valid/out_ready. No other combinational input-to-output path exists.
- Reset (asynchronous, any time including mid-stream): all stage valids, out_valid, data_out, flags, err_pos and counters go to 0, and any in-flight codeword is discarded. in_ready=1 during and after reset.
- Counter values reflect a delivery on the cycle after the handshake.

## Configuration

- HAMMING_DEC_CNT_EN: when defined, the corr_cnt/uncorr_cnt registers and clr_cnt logic are built.
- When undefined:
  - corr_cnt and uncorr_cnt are tied to 0.
  - clr_cnt is ignored.
  - No counter flops are synthesised.
  - Decode, handshake and timing are unchanged.

## Test plan

All scenarios use DATA_W=4 and PAR_W=3; the clean codeword for data 4'b1011 is 8'h55.

- Send 8'h55 -> 2 cycles later out_valid=1, data_out=4'b1011, both flags 0, err_pos=0.
- Send 8'h45 (bit 4 / position 5 flipped) -> data_out=4'b1011, err_correctable=1, err_pos=5, corr_cnt=1 after the handshake.
- Send 8'hD5 (overall parity bit flipped) -> data_out=4'b1011, err_correctable=1, err_pos=0. Send 8'h56 (positions 1 and 2 flipped) -> err_uncorrectable=1, err_pos=3, data_out=4'b1011 raw, uncorr_cnt=1.
- Hold out_ready=0 while streaming 8'h55 then 8'h45 -> in_ready=0 after the pipe fills, and output stays at the first result until out_ready=1. Both results are then delivered in order with no loss or duplication.
- Deliver 300 consecutive results from 8'h45 with CNT_EN built -> corr_cnt saturates at 255. Assert clr_cnt on a delivery cycle -> corr_cnt=0.
- Assert rstn=0 with two codewords in flight -> out_valid=0 immediately and both counters=0. After release, the first new codeword emerges with 2-cycle latency.

Source files
------------

// File: rtl/hamming_secded_dec_p_if.sv
// ---------------------------------------------------------------------------
// hamming_secded_dec_p_if
//   Interface bundle for the pipelined SECDED decoder.
//
//   Handshake semantics (both sides): a transfer happens on a rising clock
//   edge where valid && ready are both 1. Once valid is raised, the producer
//   holds valid and its payload stable until the transfer. ready may change
//   freely and never depends on valid of the same side.
//
//   Signals
//     in_valid / in_ready / data_in       : codeword input (N bits)
//     out_valid / out_ready               : result output
//     data_out, err_correctable,
//     err_uncorrectable, err_pos          : result payload
//
//   Modports
//     master : environment side (drives codewords, consumes results)
//     slave  : decoder side
// ---------------------------------------------------------------------------
interface hamming_secded_dec_p_if #(
  parameter int DATA_W = 4,
  parameter int PAR_W  = 3
);
  localparam int N = DATA_W + PAR_W + 1;

  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      data_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] data_out;
  logic              err_correctable;
  logic              err_uncorrectable;
  logic [PAR_W-1:0]  err_pos;

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, err_correctable,
           err_uncorrectable, err_pos
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, err_correctable,
           err_uncorrectable, err_pos
  );
endinterface

// File: rtl/hamming_secded_dec_p.sv
// ---------------------------------------------------------------------------
// hamming_secded_dec_p
//   Two-stage pipelined SECDED (extended Hamming) decoder. Corrects any
//   single-bit error, flags double-bit and invalid-syndrome errors, and
//   reports the syndrome of every result.
//
//   Codeword layout: data_in[i] is Hamming position i+1 for i < N-1, the MSB
//   is overall even parity. Parity bit j sits at position 2^j; data bits fill
//   the remaining positions in ascending order (data_out[0] = position 3).
//
//   Ports
//     clk, rstn       : clock (rising edge), asynchronous active-low reset
//     bus (slave)     : in_valid/in_ready/data_in, out_valid/out_ready,
//                       data_out, err_correctable, err_uncorrectable, err_pos
//     clr_cnt         : synchronous clear of both error counters
//     corr_cnt        : saturating count of delivered correctable results
//     uncorr_cnt      : saturating count of delivered uncorrectable results
//
//   Build option
//     HAMMING_DEC_CNT_EN : when defined, the error counters are built;
//                          otherwise they read 0 and clr_cnt is ignored.
// ---------------------------------------------------------------------------
module hamming_secded_dec_p #(
  parameter int DATA_W = 4,
  parameter int PAR_W  = 3,
  parameter int CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  hamming_secded_dec_p_if.slave  bus,
  input  logic                   clr_cnt,
  output logic [CNT_W-1:0]       corr_cnt,
  output logic [CNT_W-1:0]       uncorr_cnt
);
  localparam int N = DATA_W + PAR_W + 1;
  // Highest Hamming position present in the (possibly shortened) code.
  localparam logic [PAR_W-1:0] MAX_POS = PAR_W'(N - 1);

  generate
    if ((2 ** PAR_W) < N) begin : g_bad_params
      $error("hamming_secded_dec_p: PAR_W too small for DATA_W");
    end
  endgenerate

  // Syndrome = XOR of the indices of all set bits among positions 1..N-1.
  function automatic logic [PAR_W-1:0] syndrome(input logic [N-1:0] c);
    logic [PAR_W-1:0] s;
    logic [N-1:0]     sh;
    s = '0;
    for (int p = 1; p < N; p++) begin
      sh = c >> (p - 1);
      if (sh[0]) s = s ^ PAR_W'(p);
    end
    return s;
  endfunction

  // Gather the non-power-of-two positions, lowest position ending up in bit 0.
  function automatic logic [DATA_W-1:0] extract(input logic [N-1:0] c);
    logic [DATA_W-1:0] d;
    logic [N-1:0]      sh;
    d = '0;
    for (int p = 3; p < N; p++) begin
      if ((p & (p - 1)) != 0) begin
        sh = c >> (p - 1);
        d  = (d >> 1) | (DATA_W'(sh[0]) << (DATA_W - 1));
      end
    end
    return d;
  endfunction

  // Single global enable: everything advances unless a result is stalled.
  logic en;
  assign en           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;

  // Stage 1: raw codeword plus its syndrome and overall parity.
  logic             s1_valid;
  logic [N-1:0]     s1_code;
  logic [PAR_W-1:0] s1_syn;
  logic             s1_par;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
    end else if (en) begin
      s1_valid <= bus.in_valid;
      s1_code  <= bus.data_in;
      s1_syn   <= syndrome(bus.data_in);
      s1_par   <= ^bus.data_in;
    end
  end

  // Stage 2 combinational: classify and correct.
  logic              corr_c;
  logic              uncorr_c;
  logic [N-1:0]      flip_mask;
  logic [DATA_W-1:0] data_c;

  always_comb begin
    corr_c    = s1_par && (s1_syn <= MAX_POS);
    uncorr_c  = s1_par ? (s1_syn > MAX_POS) : (s1_syn != '0);
    flip_mask = '0;
    // Syndrome 0 with a parity error means the overall parity bit itself
    // was hit, so the data positions stay untouched.
    if (corr_c && (s1_syn != '0))
      flip_mask = {{(N-1){1'b0}}, 1'b1} << (s1_syn - PAR_W'(1));
    data_c = extract(s1_code ^ flip_mask);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.out_valid         <= 1'b0;
      bus.data_out          <= '0;
      bus.err_correctable   <= 1'b0;
      bus.err_uncorrectable <= 1'b0;
      bus.err_pos           <= '0;
    end else if (en) begin
      bus.out_valid         <= s1_valid;
      bus.data_out          <= data_c;
      bus.err_correctable   <= s1_valid && corr_c;
      bus.err_uncorrectable <= s1_valid && uncorr_c;
      bus.err_pos           <= s1_syn;
    end
  end

`ifdef HAMMING_DEC_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic delivered;
  assign delivered = bus.out_valid && bus.out_ready;

  // Clear has priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (clr_cnt) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (delivered) begin
      if (bus.err_correctable && (corr_cnt != CNT_MAX))
        corr_cnt <= corr_cnt + CNT_W'(1);
      if (bus.err_uncorrectable && (uncorr_cnt != CNT_MAX))
        uncorr_cnt <= uncorr_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_clr_cnt;
  assign unused_clr_cnt = clr_cnt;
  assign corr_cnt       = '0;
  assign uncorr_cnt     = '0;
`endif

endmodule

// File: tb/tb_hamming_secded_dec_p.sv
// ---------------------------------------------------------------------------
// tb_hamming_secded_dec_p
//   Self-checking bench for hamming_secded_dec_p (DATA_W=4, PAR_W=3).
//   Stimulus is issued by driver tasks that push the expected result into
//   exp_q; an independent monitor pops and compares on every delivery, and
//   also tracks the error counters against a saturating model.
// ---------------------------------------------------------------------------
module tb_hamming_secded_dec_p;
  localparam int DATA_W = 4;
  localparam int PAR_W  = 3;
  localparam int CNT_W  = 8;
  localparam int N      = 8;
  localparam int W      = DATA_W + 2 + PAR_W;
`ifdef HAMMING_DEC_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b1;
  logic clr_cnt = 1'b0;
  logic [CNT_W-1:0] corr_cnt;
  logic [CNT_W-1:0] uncorr_cnt;

  always #5 clk = ~clk;

  hamming_secded_dec_p_if #(.DATA_W(DATA_W), .PAR_W(PAR_W)) bus ();

  hamming_secded_dec_p #(.DATA_W(DATA_W), .PAR_W(PAR_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus.slave),
    .clr_cnt    (clr_cnt),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           acc_q[$];      // accept cycle, -1 when latency is not checked
  int           n_checks = 0;
  int           n_pass   = 0;
  int           cyc      = 0;
  int           mode     = 0;  // 0: out_ready=1, 1: random, 2: out_ready=0
  bit           want_clr = 1'b0;
  int           m_corr   = 0;
  int           m_uncorr = 0;
  bit           hold_prev = 1'b0;
  logic [W-1:0] snap;

  localparam logic [W-1:0] EXP_55 = {4'b1011, 1'b0, 1'b0, 3'd0};
  localparam logic [W-1:0] EXP_45 = {4'b1011, 1'b1, 1'b0, 3'd5};
  localparam logic [W-1:0] EXP_D5 = {4'b1011, 1'b1, 1'b0, 3'd0};
  localparam logic [W-1:0] EXP_56 = {4'b1011, 1'b0, 1'b1, 3'd3};

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  // Syndrome bit j = parity of all positions whose index has bit j set.
  function automatic logic [W-1:0] ref_decode(input logic [7:0] cw);
    int         s;
    int         ones;
    int         par;
    logic [7:0] c;
    logic [3:0] d;
    bit         corr;
    bit         unc;
    int         dpos[4] = '{3, 5, 6, 7};
    s = 0;
    for (int j = 0; j < 3; j++) begin
      ones = 0;
      for (int p = 1; p < 8; p++)
        if ((p & (1 << j)) != 0) ones += int'(cw[p-1]);
      if ((ones % 2) == 1) s += (1 << j);
    end
    par  = $countones(cw) % 2;
    c    = cw;
    corr = 1'b0;
    unc  = 1'b0;
    if (par == 1 && s <= 7) begin
      corr = 1'b1;
      if (s > 0) c[s-1] = ~c[s-1];
    end else if (par == 1 || s != 0) begin
      unc = 1'b1;
    end
    for (int k = 0; k < 4; k++) d[k] = c[dpos[k]-1];
    return {d, corr, unc, 3'(s)};
  endfunction

  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [7:0] c;
    int         ones;
    int         dpos[4] = '{3, 5, 6, 7};
    c = '0;
    for (int k = 0; k < 4; k++) c[dpos[k]-1] = d[k];
    for (int j = 0; j < 3; j++) begin
      ones = 0;
      for (int p = 1; p < 8; p++)
        if ((p & (1 << j)) != 0) ones += int'(c[p-1]);
      c[(1 << j) - 1] = ((ones % 2) == 1);
    end
    c[7] = ^c[6:0];
    return c;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] cw, input logic [W-1:0] e);
    int waited = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.data_in  = cw;
    #2;
    while (!bus.in_ready && waited < 1000) begin
      @(negedge clk);
      #2;
      waited++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", bus.in_ready, 1);
      bus.in_valid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    acc_q.push_back(mode == 0 ? cyc + 1 : -1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() > 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] act;
    int           a;
    bit           clr_now;
    bit           deliver;
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rstn) begin
        chk("corr_cnt", corr_cnt, CNT_EN ? m_corr : 0);
        chk("uncorr_cnt", uncorr_cnt, CNT_EN ? m_uncorr : 0);
      end
      act = {bus.data_out, bus.err_correctable, bus.err_uncorrectable, bus.err_pos};
      if (hold_prev) begin
        chk("hold_payload", act, snap);
        chk("hold_valid", bus.out_valid, 1);
      end
      case (mode)
        0:       bus.out_ready = 1'b1;
        2:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      clr_now  = want_clr;
      want_clr = 1'b0;
      clr_cnt  = clr_now;
      #1;
      if (rstn) chk("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
      deliver   = rstn && bus.out_valid && bus.out_ready;
      hold_prev = rstn && bus.out_valid && !bus.out_ready;
      snap      = act;
      if (deliver) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", bus.out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("result", act, e);
          if (a >= 0 && mode == 0) chk("latency", cyc + 1 - a, 2);
        end
      end
      if (clr_now) begin
        m_corr   = 0;
        m_uncorr = 0;
      end else if (deliver && exp_q.size() >= 0) begin
        if (e[4] && m_corr < 255) m_corr++;
        if (e[3] && m_uncorr < 255) m_uncorr++;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] cw;
    int         a;
    int         b;
    int         nerr;
    bus.in_valid = 1'b0;
    bus.data_in  = '0;

    // Reset state
    #2 rstn = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_payload", {bus.data_out, bus.err_correctable, bus.err_uncorrectable, bus.err_pos}, 0);
    chk("rst_corr_cnt", corr_cnt, 0);
    chk("rst_uncorr_cnt", uncorr_cnt, 0);
    repeat (2) @(negedge clk);
    #2 rstn = 1'b1;

    // Directed codewords
    mode = 0;
    send(8'h55, EXP_55);
    send(8'h45, EXP_45);
    send(8'hD5, EXP_D5);
    send(8'h56, EXP_56);
    drain();

    // Stall: output holds, in_ready low once the pipe is full
    mode = 2;
    send(8'h55, EXP_55);
    send(8'h45, EXP_45);
    repeat (4) begin
      @(negedge clk);
      #2;
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_payload", {bus.data_out, bus.err_correctable, bus.err_uncorrectable, bus.err_pos}, EXP_55);
    end
    mode = 0;
    drain();

    // Randomized traffic: 0/1/2 flips on clean codewords, some raw words
    for (int ph = 0; ph < 2; ph++) begin
      mode = (ph == 0) ? 1 : 0;
      repeat (300) begin
        cw   = encode(4'($urandom));
        nerr = $urandom_range(0, 2);
        a    = $urandom_range(0, 7);
        if (nerr >= 1) cw[a] = ~cw[a];
        if (nerr == 2) begin
          b     = (a + $urandom_range(1, 7)) % 8;
          cw[b] = ~cw[b];
        end
        if ($urandom_range(0, 7) == 0) cw = 8'($urandom);
        send(cw, ref_decode(cw));
        if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      drain();
    end

    // Counter saturation, then clear on a delivery cycle
    mode = 0;
    for (int i = 0; i < 310; i++) begin
      if (i == 305) want_clr = 1'b1;
      send(8'h45, EXP_45);
    end
    drain();
    repeat (3) send(8'h56, EXP_56);
    drain();

    // Asynchronous reset with two codewords in flight
    send(8'h45, EXP_45);
    send(8'h56, EXP_56);
    #3;
    rstn = 1'b0;
    exp_q.delete();
    acc_q.delete();
    m_corr    = 0;
    m_uncorr  = 0;
    hold_prev = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_corr_cnt", corr_cnt, 0);
    chk("midrst_uncorr_cnt", uncorr_cnt, 0);
    repeat (2) @(negedge clk);
    #3 rstn = 1'b1;
    send(8'h55, EXP_55);
    send(8'h45, EXP_45);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
